// File: rtl/time_edit_controller.sv
// Time-set sequencer for the clock: captures, edits and commits hh:mm:ss
// and drives the blink mask/phase for the 7-segment digit displayers.
module time_edit_controller #(
    parameter int HALF_PERIOD = 6250000,
    parameter int TIMEOUT     = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic [5:0] edit_sec,
    output logic       commit,
    output logic       edit_active,
    output logic [5:0] blink_mask,
    output logic       blink_on
);

    localparam int BW = $clog2(HALF_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    localparam logic [5:0] MASK_HOUR = 6'b110000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_SEC  = 6'b000011;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_HOUR,
        EDIT_MIN,
        EDIT_SEC
    } state_t;

    state_t        state;
    logic [BW-1:0] blink_cnt;
    logic [TW-1:0] to_cnt;

    logic any_btn;
    logic timed_out;
    logic finish;
    logic leave;

    // Up and down together cancel out: no step, but still activity.
    function automatic logic [4:0] step_hour(
        input logic [4:0] v,
        input logic       up,
        input logic       dn
    );
        logic [4:0] r;
        r = v;
        if (up && !dn)
            r = (v == 5'd23) ? 5'd0 : v + 5'd1;
        else if (dn && !up)
            r = (v == 5'd0) ? 5'd23 : v - 5'd1;
        return r;
    endfunction

    function automatic logic [5:0] step_60(
        input logic [5:0] v,
        input logic       up,
        input logic       dn
    );
        logic [5:0] r;
        r = v;
        if (up && !dn)
            r = (v == 6'd59) ? 6'd0 : v + 6'd1;
        else if (dn && !up)
            r = (v == 6'd0) ? 6'd59 : v - 6'd1;
        return r;
    endfunction

    always_comb begin
        any_btn   = btn_set | btn_up | btn_down;
        timed_out = (state != IDLE) && !any_btn && (to_cnt == TO_LAST);
        finish    = (state == EDIT_SEC) && btn_set;
        leave     = timed_out | finish;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            edit_hour   <= '0;
            edit_min    <= '0;
            edit_sec    <= '0;
            commit      <= 1'b0;
            edit_active <= 1'b0;
            blink_mask  <= '0;
            blink_on    <= 1'b1;
            blink_cnt   <= '0;
            to_cnt      <= '0;
        end else begin
            commit <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (btn_set) begin
                        state       <= EDIT_HOUR;
                        edit_hour   <= cur_hour;
                        edit_min    <= cur_min;
                        edit_sec    <= cur_sec;
                        edit_active <= 1'b1;
                        blink_mask  <= MASK_HOUR;
                    end
                end
                EDIT_HOUR: begin
                    if (btn_set) begin
                        state      <= EDIT_MIN;
                        blink_mask <= MASK_MIN;
                    end else if (!timed_out) begin
                        edit_hour <= step_hour(edit_hour, btn_up, btn_down);
                    end
                end
                EDIT_MIN: begin
                    if (btn_set) begin
                        state      <= EDIT_SEC;
                        blink_mask <= MASK_SEC;
                    end else if (!timed_out) begin
                        edit_min <= step_60(edit_min, btn_up, btn_down);
                    end
                end
                EDIT_SEC: begin
                    if (btn_set) begin
                        commit <= 1'b1;
                    end else if (!timed_out) begin
                        edit_sec <= step_60(edit_sec, btn_up, btn_down);
                    end
                end
                default: state <= IDLE;
            endcase

            if (leave) begin
                state       <= IDLE;
                edit_active <= 1'b0;
                blink_mask  <= '0;
            end

            // Blink and timeout only run while editing; any press
            // restarts the phase so the edited digit shows at once.
            if (state == IDLE || leave || any_btn) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
                to_cnt    <= '0;
            end else begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
                if (to_cnt != TO_LAST)
                    to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_edit_controller.sv
// Directed bench for time_edit_controller with HALF_PERIOD=4, TIMEOUT=20.
module tb_time_edit_controller;

    logic       clk;
    logic       reset;
    logic       btn_set;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic [5:0] edit_sec;
    logic       commit;
    logic       edit_active;
    logic [5:0] blink_mask;
    logic       blink_on;

    int checks;
    int errors;
    int commits_seen;
    int base;

    time_edit_controller #(
        .HALF_PERIOD(4),
        .TIMEOUT(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_set(btn_set),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .cur_hour(cur_hour),
        .cur_min(cur_min),
        .cur_sec(cur_sec),
        .edit_hour(edit_hour),
        .edit_min(edit_min),
        .edit_sec(edit_sec),
        .commit(commit),
        .edit_active(edit_active),
        .blink_mask(blink_mask),
        .blink_on(blink_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset && commit)
            commits_seen++;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic u, input logic d);
        btn_set  = s;
        btn_up   = u;
        btn_down = d;
        tick();
        btn_set  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic check_time(
        input string      tag,
        input logic [4:0] h,
        input logic [5:0] m,
        input logic [5:0] s
    );
        check({tag, "_hour"}, 32'(edit_hour), 32'(h));
        check({tag, "_min"}, 32'(edit_min), 32'(m));
        check({tag, "_sec"}, 32'(edit_sec), 32'(s));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        commits_seen = 0;
        reset        = 1'b1;
        btn_set      = 1'b0;
        btn_up       = 1'b0;
        btn_down     = 1'b0;
        cur_hour     = 5'd12;
        cur_min      = 6'd34;
        cur_sec      = 6'd56;
        tick();
        tick();
        reset = 1'b0;

        check_time("rst", 5'd0, 6'd0, 6'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_active", 32'(edit_active), 32'd0);
        check("rst_mask", 32'(blink_mask), 32'd0);
        check("rst_blink", 32'(blink_on), 32'd1);

        // Buttons other than set are ignored in IDLE.
        press(1'b0, 1'b1, 1'b0);
        check("idle_up_active", 32'(edit_active), 32'd0);
        check("idle_up_hour", 32'(edit_hour), 32'd0);

        press(1'b1, 1'b0, 1'b0);
        check_time("enter", 5'd12, 6'd34, 6'd56);
        check("enter_mask", 32'(blink_mask), 32'b110000);
        check("enter_active", 32'(edit_active), 32'd1);
        check("enter_blink", 32'(blink_on), 32'd1);

        for (int i = 0; i < 11; i++)
            press(1'b0, 1'b1, 1'b0);
        check("hour_to_23", 32'(edit_hour), 32'd23);
        press(1'b0, 1'b1, 1'b0);
        check_time("hour_wrap_up", 5'd0, 6'd34, 6'd56);
        press(1'b0, 1'b0, 1'b1);
        check_time("hour_wrap_dn", 5'd23, 6'd34, 6'd56);

        press(1'b1, 1'b1, 1'b0);
        check("setup_mask", 32'(blink_mask), 32'b001100);
        check("setup_hour", 32'(edit_hour), 32'd23);

        for (int i = 0; i < 4; i++)
            tick();
        check("min_blink_off", 32'(blink_on), 32'd0);
        press(1'b0, 1'b1, 1'b1);
        check("updn_min", 32'(edit_min), 32'd34);
        check("updn_blink", 32'(blink_on), 32'd1);

        // Timeout: 20 idle cycles in EDIT_MIN returns to IDLE.
        base = commits_seen;
        for (int i = 0; i < 19; i++)
            tick();
        check("to_still_active", 32'(edit_active), 32'd1);
        check("to_still_mask", 32'(blink_mask), 32'b001100);
        tick();
        check("to_idle_active", 32'(edit_active), 32'd0);
        check("to_idle_mask", 32'(blink_mask), 32'd0);
        check("to_no_commit", 32'(commits_seen - base), 32'd0);

        cur_hour = 5'd12;
        cur_min  = 6'd34;
        cur_sec  = 6'd0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("min_up", 32'(edit_min), 32'd35);
        press(1'b1, 1'b0, 1'b0);
        check("sec_mask", 32'(blink_mask), 32'b000011);
        press(1'b0, 1'b0, 1'b1);
        check_time("sec_wrap_dn", 5'd12, 6'd35, 6'd59);

        for (int i = 0; i < 6; i++) begin
            check($sformatf("cad_a%0d", i), 32'(blink_on),
                  (i < 4) ? 32'd1 : 32'd0);
            if (i < 5)
                tick();
        end
        press(1'b0, 1'b1, 1'b0);
        check("restart_sec", 32'(edit_sec), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("cad_b%0d", i), 32'(blink_on),
                  (i < 4) ? 32'd1 : 32'd0);
            if (i < 4)
                tick();
        end
        press(1'b0, 1'b0, 1'b1);
        check("sec_back", 32'(edit_sec), 32'd59);

        base = commits_seen;
        press(1'b1, 1'b0, 1'b0);
        check("commit_pulse", 32'(commit), 32'd1);
        check_time("commit", 5'd12, 6'd35, 6'd59);
        check("commit_active", 32'(edit_active), 32'd0);
        check("commit_mask", 32'(blink_mask), 32'd0);
        tick();
        check("commit_drop", 32'(commit), 32'd0);
        check_time("after_commit", 5'd12, 6'd35, 6'd59);
        tick();
        check("commit_count", 32'(commits_seen - base), 32'd1);

        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("pre_rst_mask", 32'(blink_mask), 32'b000011);
        base = commits_seen;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_time("mid_rst", 5'd0, 6'd0, 6'd0);
        check("mid_rst_active", 32'(edit_active), 32'd0);
        check("mid_rst_mask", 32'(blink_mask), 32'd0);
        check("mid_rst_commit", 32'(commit), 32'd0);
        tick();
        tick();
        check("mid_rst_no_commit", 32'(commits_seen - base), 32'd0);
        check("mid_rst_blink", 32'(blink_on), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
